// File: rtl/spi_flash_ctrl_if.sv
// Command / data handshake bundle between system logic and spi_flash_ctrl.
// master: system side (parameter store, log buffers). slave: the controller.
interface spi_flash_ctrl_if;
  logic        cmd_req;
  logic        cmd_rw;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_ack;
  logic        busy;
  logic        done;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_vld;

  modport master (
    output cmd_req, cmd_rw, cmd_bank, cmd_addr, cmd_len, wr_data, wr_valid,
    input  cmd_ack, busy, done, wr_ready, rd_data, rd_vld
  );

  modport slave (
    input  cmd_req, cmd_rw, cmd_bank, cmd_addr, cmd_len, wr_data, wr_valid,
    output cmd_ack, busy, done, wr_ready, rd_data, rd_vld
  );
endinterface

// File: rtl/spi_flash_ctrl.sv
// SPI mode-0 master for an external serial flash. One read or write burst per
// request: opcode, bank byte, address high, address low, then cmd_len data bytes.
// Optional macro SPI_WREN_PREFIX_EN: write frames start with a 0x06 byte inside
// the same chip-select frame (5-byte write header instead of 4).
module spi_flash_ctrl #(
  parameter int CLK_DIV = 4,  // sck half-period in clk cycles (>=2)
  parameter int CS_GAP  = 8   // minimum csn high time after a frame (>=1)
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_flash_ctrl_if.slave bus,
  output logic            spi_csn,
  output logic            spi_sck,
  output logic            spi_sdi,
  input  logic            spi_sdo
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CS_SETUP = 3'd1;
  localparam logic [2:0] S_HDR      = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_CS_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  localparam logic [7:0]  OP_READ  = 8'h03;
  localparam logic [7:0]  OP_WRITE = 8'h02;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

  logic [2:0]  state;
  logic [15:0] tmr;        // half-period / setup / hold / gap timer
  logic        rw;
  logic [15:0] byte_cnt;   // data bytes still to transfer
  logic [7:0]  tx_shift;
  logic [7:0]  rx_shift;
  logic [31:0] hdr_rest;   // header bytes queued after the one in tx_shift
  logic [2:0]  hdr_cnt;    // number of valid bytes left in hdr_rest
  logic [2:0]  bit_cnt;
  logic        need_load;  // write data: waiting for the next wr_data byte
  logic        tick;
  logic        load_now;
  logic [7:0]  hdr_first;
  logic [31:0] hdr_tail;
  logic [2:0]  hdr_extra;

  assign tick     = (tmr == DIV_LAST);
  // The byte is consumed in the very cycle wr_ready is high, so it must be
  // combinational rather than a registered echo of wr_valid.
  assign load_now = (state == S_DATA) && rw && need_load && bus.wr_valid;
  assign bus.wr_ready = load_now;

  // Header layout for the request on the bus, captured when it is accepted.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    hdr_first = bus.cmd_rw ? OP_WRITE : OP_READ;
    hdr_tail  = {6'b0, bus.cmd_bank, bus.cmd_addr, 8'h00};
    hdr_extra = 3'd3;
`ifdef SPI_WREN_PREFIX_EN
    if (bus.cmd_rw) begin
      hdr_first = 8'h06;
      hdr_tail  = {OP_WRITE, 6'b0, bus.cmd_bank, bus.cmd_addr};
      hdr_extra = 3'd4;
    end
`endif
  end

  // Frame sequencer, sck generator and shift registers.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge value of every other; blocking here would chain them.
    if (!rst_n) begin
      state       <= S_IDLE;
      tmr         <= '0;
      rw          <= 1'b0;
      byte_cnt    <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      hdr_rest    <= '0;
      hdr_cnt     <= '0;
      bit_cnt     <= '0;
      need_load   <= 1'b0;
      spi_csn     <= 1'b1;
      spi_sck     <= 1'b0;
      spi_sdi     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.cmd_ack <= 1'b0;
      bus.done    <= 1'b0;
      bus.rd_vld  <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      bus.cmd_ack <= 1'b0;
      bus.done    <= 1'b0;
      bus.rd_vld  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_req) begin
            rw          <= bus.cmd_rw;
            byte_cnt    <= bus.cmd_len;
            tx_shift    <= hdr_first;
            hdr_rest    <= hdr_tail;
            hdr_cnt     <= hdr_extra;
            bit_cnt     <= '0;
            need_load   <= 1'b0;
            spi_sdi     <= hdr_first[7];
            spi_csn     <= 1'b0;
            bus.busy    <= 1'b1;
            bus.cmd_ack <= 1'b1;
            tmr         <= '0;
            state       <= S_CS_SETUP;
          end
        end

        // csn low, sck low for CLK_DIV cycles; the exit edge is the first rise.
        S_CS_SETUP: begin
          if (tick) begin
            tmr     <= '0;
            spi_sck <= 1'b1;
            state   <= S_HDR;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end

        S_HDR, S_DATA: begin
          if (load_now) begin
            tx_shift  <= bus.wr_data;
            spi_sdi   <= bus.wr_data[7];
            need_load <= 1'b0;
            tmr       <= '0;
          end else if (need_load) begin
            tmr <= '0;  // stalled on wr_valid with sck low
          end else if (!tick) begin
            tmr <= tmr + 16'd1;
          end else begin
            tmr <= '0;
            if (!spi_sck) begin
              spi_sck  <= 1'b1;
              rx_shift <= {rx_shift[6:0], spi_sdo};
              if (state == S_DATA && !rw && bit_cnt == 3'd7) begin
                bus.rd_data <= {rx_shift[6:0], spi_sdo};
                bus.rd_vld  <= 1'b1;
              end
            end else begin
              spi_sck <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt != 3'd7) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                spi_sdi  <= tx_shift[6];
              end else if (state == S_HDR) begin
                if (hdr_cnt != 3'd0) begin
                  tx_shift <= hdr_rest[31:24];
                  spi_sdi  <= hdr_rest[31];
                  hdr_rest <= {hdr_rest[23:0], 8'h00};
                  hdr_cnt  <= hdr_cnt - 3'd1;
                end else begin
                  tx_shift <= '0;
                  spi_sdi  <= 1'b0;
                  if (byte_cnt == 16'd0) begin
                    state <= S_CS_HOLD;
                  end else begin
                    state     <= S_DATA;
                    need_load <= rw;
                  end
                end
              end else begin
                // Read bytes shift zeros out on sdi.
                byte_cnt <= byte_cnt - 16'd1;
                tx_shift <= '0;
                spi_sdi  <= 1'b0;
                if (byte_cnt == 16'd1) begin
                  state <= S_CS_HOLD;
                end else begin
                  need_load <= rw;
                end
              end
            end
          end
        end

        // Keep csn low for CLK_DIV cycles after the final falling edge.
        S_CS_HOLD: begin
          if (tick) begin
            tmr     <= '0;
            spi_csn <= 1'b1;
            state   <= S_GAP;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end

        // Enforce the minimum csn-high time, then release the requester.
        S_GAP: begin
          if (tmr == GAP_LAST) begin
            tmr      <= '0;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Directed self-checking bench for spi_flash_ctrl with a behavioural SPI flash.
module tb_spi_flash_ctrl;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 8;
`ifdef SPI_WREN_PREFIX_EN
  localparam int WR_HDR = 5;
`else
  localparam int WR_HDR = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_csn, spi_sck, spi_sdi;
  logic spi_sdo = 1'b0;

  spi_flash_ctrl_if bus ();

  spi_flash_ctrl #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .spi_csn (spi_csn),
    .spi_sck (spi_sck),
    .spi_sdi (spi_sdi),
    .spi_sdo (spi_sdo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Write data source.
  logic [7:0] wdata [4];
  int widx  = 0;
  int wbase = 0;
  assign bus.wr_data = wdata[2'(widx - wbase)];
  always @(posedge clk) if (bus.wr_ready && bus.wr_valid) widx <= widx + 1;

  // Behavioural flash: captures sdi bytes per frame, serves reads from mem.
  logic [7:0] mem [0:255];
  logic [7:0] cap [$];
  int bits = 0;
  logic [7:0] cur;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
  end
  always @(posedge spi_sck or negedge spi_csn) begin
    if (spi_sck) begin
      cur  = {cur[6:0], spi_sdi};
      bits = bits + 1;
      if (bits % 8 == 0) cap.push_back(cur);
    end else begin
      cap.delete();
      bits = 0;
    end
  end
  always @(negedge spi_sck) begin : flash_out
    int k;
    logic [7:0] a;
    if (bits >= 32 && cap.size() >= 4 && cap[0] == 8'h03) begin
      k = bits - 32;
      a = cap[3] + 8'(k / 8);
      spi_sdo = mem[a][7 - (k % 8)];
    end
  end

  // Output monitors.
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  logic [7:0] rdq [$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.wr_ready && bus.wr_valid) wr_cnt++;
    if (bus.rd_vld) begin rd_cnt++; rdq.push_back(bus.rd_data); end
    if (bus.done) done_cnt++;
  end

  task automatic issue_cmd(input logic rw, input logic [1:0] bank,
                           input logic [15:0] addr, input logic [15:0] len, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.cmd_rw = rw; bus.cmd_bank = bank; bus.cmd_addr = addr; bus.cmd_len = len;
    bus.cmd_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cmd_ack === 1'b1) begin ok = 1'b1; break; end
    end
    bus.cmd_req = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (spi_csn !== 1'b1) begin bad++; $display("FAIL reset_csn got=%b want=1", spi_csn); end
    total++; if (spi_sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", spi_sck); end
    total++; if (spi_sdi !== 1'b0) begin bad++; $display("FAIL reset_sdi got=%b want=0", spi_sdi); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.cmd_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", bus.cmd_ack); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%b want=0", bus.wr_ready); end
    total++; if (bus.rd_vld !== 1'b0) begin bad++; $display("FAIL reset_rd_vld got=%b want=0", bus.rd_vld); end
    total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h want=00", bus.rd_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int d0;
    d0 = done_cnt;
    issue_cmd(1'b0, 2'd0, 16'h0010, 16'd4, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_ack got=none want=ack"); end
    for (int i = 0; i < 2000 && bits < 12; i++) @(negedge clk);
    total++; if (bits < 12) begin bad++; $display("FAIL midrst_reach_byte2 got=%0d bits want>=12", bits); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (spi_csn !== 1'b1) begin bad++; $display("FAIL midrst_csn got=%b want=1", spi_csn); end
    total++; if (spi_sck !== 1'b0) begin bad++; $display("FAIL midrst_sck got=%b want=0", spi_sck); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", done_cnt - d0); end
  endtask

  task automatic test_write;
    bit ok;
    int w0, d0;
    logic [7:0] exp [$];
`ifdef SPI_WREN_PREFIX_EN
    exp.push_back(8'h06);
`endif
    exp.push_back(8'h02); exp.push_back(8'h02); exp.push_back(8'h12); exp.push_back(8'h34);
    exp.push_back(8'hA5); exp.push_back(8'h5A); exp.push_back(8'hFF);
    wdata = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    wbase = widx;
    w0 = wr_cnt; d0 = done_cnt;
    bus.wr_valid = 1'b1;
    issue_cmd(1'b1, 2'd2, 16'h1234, 16'd3, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_ack got=none want=ack"); end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_done_timeout got=none want=done"); end
    bus.wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (cap.size() != exp.size()) begin bad++; $display("FAIL wr_nbytes got=%0d want=%0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      total++; if (cap[i] !== exp[i]) begin bad++; $display("FAIL wr_byte%0d got=%h want=%h", i, cap[i], exp[i]); end
    end
    total++; if (bits != 8 * (WR_HDR + 3)) begin bad++; $display("FAIL wr_rises got=%0d want=%0d", bits, 8 * (WR_HDR + 3)); end
    total++; if (wr_cnt - w0 != 3) begin bad++; $display("FAIL wr_ready_pulses got=%0d want=3", wr_cnt - w0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL wr_done_pulses got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_write_stall;
    bit ok;
    int w0, viol;
    logic [7:0] exp [$];
`ifdef SPI_WREN_PREFIX_EN
    exp.push_back(8'h06);
`endif
    exp.push_back(8'h02); exp.push_back(8'h02); exp.push_back(8'h12); exp.push_back(8'h34);
    exp.push_back(8'hA5); exp.push_back(8'h5A); exp.push_back(8'hFF);
    wdata = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    wbase = widx;
    w0 = wr_cnt;
    bus.wr_valid = 1'b1;
    issue_cmd(1'b1, 2'd2, 16'h1234, 16'd3, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_ack got=none want=ack"); end
    for (int i = 0; i < 3000 && (widx - wbase) < 1; i++) @(negedge clk);
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 3000 && cap.size() < WR_HDR + 1; i++) @(negedge clk);
    total++; if (cap.size() != WR_HDR + 1) begin bad++; $display("FAIL stall_first_byte got=%0d bytes want=%0d", cap.size(), WR_HDR + 1); end
    for (int i = 0; i < 100 && spi_sck !== 1'b0; i++) @(negedge clk);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (spi_sck !== 1'b0 || spi_csn !== 1'b0) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL stall_pins got=%0d bad cycles want=0", viol); end
    bus.wr_valid = 1'b1;
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_done_timeout got=none want=done"); end
    bus.wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (cap.size() != exp.size()) begin bad++; $display("FAIL stall_nbytes got=%0d want=%0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      total++; if (cap[i] !== exp[i]) begin bad++; $display("FAIL stall_byte%0d got=%h want=%h", i, cap[i], exp[i]); end
    end
    total++; if (wr_cnt - w0 != 3) begin bad++; $display("FAIL stall_wr_ready got=%0d want=3", wr_cnt - w0); end
  endtask

  task automatic test_read;
    bit ok;
    int r0, q0;
    logic [7:0] exp_hdr [4];
    logic [7:0] exp_dat [4];
    exp_hdr = '{8'h03, 8'h00, 8'h00, 8'h10};
    exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    r0 = rd_cnt; q0 = rdq.size();
    issue_cmd(1'b0, 2'd0, 16'h0010, 16'd4, ok);
    total++; if (!ok) begin bad++; $display("FAIL rd_ack got=none want=ack"); end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL rd_done_timeout got=none want=done"); end
    repeat (2) @(negedge clk);
    total++; if (cap.size() != 8) begin bad++; $display("FAIL rd_nbytes got=%0d want=8", cap.size()); end
    for (int i = 0; i < 4 && i < cap.size(); i++) begin
      total++; if (cap[i] !== exp_hdr[i]) begin bad++; $display("FAIL rd_hdr%0d got=%h want=%h", i, cap[i], exp_hdr[i]); end
    end
    for (int i = 4; i < cap.size(); i++) begin
      total++; if (cap[i] !== 8'h00) begin bad++; $display("FAIL rd_sdi_idle%0d got=%h want=00", i, cap[i]); end
    end
    total++; if (rd_cnt - r0 != 4) begin bad++; $display("FAIL rd_vld_pulses got=%0d want=4", rd_cnt - r0); end
    for (int i = 0; i < 4 && q0 + i < rdq.size(); i++) begin
      total++; if (rdq[q0 + i] !== exp_dat[i]) begin bad++; $display("FAIL rd_data%0d got=%h want=%h", i, rdq[q0 + i], exp_dat[i]); end
    end
  endtask

  task automatic test_len0_read;
    bit ok;
    int r0, d0;
    logic [7:0] exp_hdr [4];
    exp_hdr = '{8'h03, 8'h03, 8'hFF, 8'hFF};
    r0 = rd_cnt; d0 = done_cnt;
    issue_cmd(1'b0, 2'd3, 16'hFFFF, 16'd0, ok);
    total++; if (!ok) begin bad++; $display("FAIL len0_ack got=none want=ack"); end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL len0_done_timeout got=none want=done"); end
    repeat (2) @(negedge clk);
    total++; if (cap.size() != 4) begin bad++; $display("FAIL len0_nbytes got=%0d want=4", cap.size()); end
    for (int i = 0; i < 4 && i < cap.size(); i++) begin
      total++; if (cap[i] !== exp_hdr[i]) begin bad++; $display("FAIL len0_hdr%0d got=%h want=%h", i, cap[i], exp_hdr[i]); end
    end
    total++; if (bits != 32) begin bad++; $display("FAIL len0_rises got=%0d want=32", bits); end
    total++; if (rd_cnt != r0) begin bad++; $display("FAIL len0_rd_vld got=%0d want=0", rd_cnt - r0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL len0_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int acks, done_cyc, ack2_cyc, run, gap;
    acks = 0; done_cyc = -1; ack2_cyc = -1; run = 0; gap = 0;
    @(negedge clk);
    bus.cmd_rw = 1'b0; bus.cmd_bank = 2'd3; bus.cmd_addr = 16'hFFFF; bus.cmd_len = 16'd0;
    bus.cmd_req = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (spi_csn === 1'b1) run++;
      else begin
        if (run > 0) gap = run;
        run = 0;
      end
      if (bus.done === 1'b1) done_cyc = cyc;
      if (bus.cmd_ack === 1'b1) begin
        acks++;
        if (acks == 2) begin ack2_cyc = cyc; break; end
      end
    end
    bus.cmd_req = 1'b0;
    total++; if (acks != 2) begin bad++; $display("FAIL b2b_acks got=%0d want=2", acks); end
    total++; if (ack2_cyc != done_cyc + 1) begin bad++; $display("FAIL b2b_ack_after_done got=%0d want=%0d", ack2_cyc, done_cyc + 1); end
    total++; if (gap < CS_GAP) begin bad++; $display("FAIL b2b_csn_gap got=%0d want>=%0d", gap, CS_GAP); end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_second_done got=none want=done"); end
  endtask

  initial begin
    bus.cmd_req = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_bank = 2'd0;
    bus.cmd_addr = 16'h0000; bus.cmd_len = 16'd0; bus.wr_valid = 1'b0;
    wdata = '{8'h00, 8'h00, 8'h00, 8'h00};
    test_reset;
    test_reset_mid_frame;
    test_write;
    test_write_stall;
    test_read;
    test_len0_read;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
